// File: rtl/fadd32_far_align_seq.sv
// Far-path alignment sequencer: right-shifts the small significand through a 48-bit
// window at most SHIFT_STEP bits per cycle, folding the bits shifted out into a sticky flag.
module fadd32_far_align_seq #(
    parameter int unsigned SHIFT_STEP = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [7:0]  exp_diff_i,
    input  logic        exp_zero_i,
    input  logic        do_sub_i,
    input  logic [23:0] sig_small_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [47:0] aligned_sig_o,
    output logic        sticky_o,
    output logic [5:0]  shift_amt_o
);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    localparam logic [5:0] StepMax = 6'(SHIFT_STEP);

    state_e      state_q, state_d;
    logic [47:0] data_q, data_d;
    logic        sticky_q, sticky_d;
    logic [5:0]  rem_q, rem_d;
    logic [5:0]  amt_q, amt_d;

    logic [8:0]  diff;
    logic [5:0]  amt_in;
    logic [5:0]  step;
    logic [63:0] lost_mask;

    // 9-bit difference so a borrow shows up in bit 8 and saturates to zero.
    assign diff = {1'b0, exp_diff_i} - {8'b0, exp_zero_i} - {8'b0, do_sub_i};

    always_comb begin
        amt_in = diff[5:0];
        if (diff[8]) begin
            amt_in = 6'd0;
        end else if (diff[7:0] > 8'd63) begin
            amt_in = 6'd63;
        end
    end

    assign step      = (rem_q < StepMax) ? rem_q : StepMax;
    assign lost_mask = (64'd1 << step) - 64'd1;

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        sticky_d = sticky_q;
        rem_d    = rem_q;
        amt_d    = amt_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    data_d   = {sig_small_i, 24'b0};
                    sticky_d = 1'b0;
                    rem_d    = amt_in;
                    amt_d    = amt_in;
                    state_d  = (amt_in == 6'd0) ? StDone : StShift;
                end
            end
            StShift: begin
                data_d   = data_q >> step;
                sticky_d = sticky_q | (|(data_q & lost_mask[47:0]));
                rem_d    = rem_q - step;
                if (rem_q == step) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        // Flush drops whatever the case above decided, including a same-cycle capture.
        if (flush_i) begin
            state_d  = StIdle;
            data_d   = data_q;
            sticky_d = sticky_q;
            rem_d    = rem_q;
            amt_d    = amt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            data_q   <= 48'd0;
            sticky_q <= 1'b0;
            rem_q    <= 6'd0;
            amt_q    <= 6'd0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            sticky_q <= sticky_d;
            rem_q    <= rem_d;
            amt_q    <= amt_d;
        end
    end

    assign in_ready_o    = (state_q == StIdle);
    assign out_valid_o   = (state_q == StDone);
    assign aligned_sig_o = data_q;
    assign sticky_o      = sticky_q;
    assign shift_amt_o   = amt_q;

endmodule
